otter_cu_fsm: RTL and testbench
===============================

// Module: otter_cu_fsm
// PURPOSE
//  Multi-cycle control FSM of the OTTER RV32I core; the sequencing half of the control unit.
//  Consumes opcode/func3 and branch flags, drives all state-changing strobes
//  (PC, regfile, memory, CSR) plus PC source select, which the decode half does not produce.
//  Sits beside the combinational decoder; owns fetch/data memory handshakes and interrupt entry.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter CU_INSTRET
// PORTS
//  CLK           in   1      core clock
//  RST           in   1      asynchronous, active-high reset
//  CU_OPCODE     in   7      instruction[6:0]
//  CU_FUNC3      in   3      instruction[14:12]
//  CU_BR_EQ      in   1      rs1==rs2
//  CU_BR_LT      in   1      rs1<rs2 signed
//  CU_BR_LTU     in   1      rs1<rs2 unsigned
//  CU_MEM_RDY    in   1      memory response for current fetch/load/store
//  CU_INTR       in   1      external interrupt level (OTTER_INTR_EN only)
//  CU_MIE        in   1      mstatus.MIE (OTTER_INTR_EN only)
//  CU_PC_WRITE   out  1      PC load strobe
//  CU_PCSOURCE   out  3      0 PC+4, 1 JALR, 2 branch, 3 JAL, 4 mtvec, 5 mepc
//  CU_RF_WE      out  1      register file write
//  CU_MEM_RDEN1  out  1      instruction fetch read
//  CU_MEM_RDEN2  out  1      data read
//  CU_MEM_WE2    out  1      data write
//  CU_CSR_WE     out  1      CSR write
//  CU_INT_TAKEN  out  1      interrupt entry pulse
//  CU_MRET_EXEC  out  1      mret executing
//  CU_STATE      out  2      FETCH=0 EXEC=1 WB=2 INTR=3
//  CU_INSTRET    out  CNT_W  retired instruction count
// BEHAVIOUR
//  - Reset: state FETCH, CU_INSTRET=0; while RST high every strobe and CU_PCSOURCE are 0.
//    Reset mid-instruction aborts it immediately; no partial write survives.
//  - Strobes are combinational from state+inputs; state and counter are registered.
//  - FETCH: RDEN1=1; hold until MEM_RDY=1, then EXEC.
//  - EXEC, by opcode (PCSOURCE=0 unless stated):
//    OP/OP_IMM/LUI/AUIPC: RF_WE=1, PC_WRITE=1.
//    JAL: RF_WE=1, PC_WRITE=1, PCSOURCE=3.  JALR: same with PCSOURCE=1.
//    BRANCH: PC_WRITE=1; PCSOURCE=2 if taken else 0. Taken: 000 EQ, 001 !EQ,
//      100 LT, 101 !LT, 110 LTU, 111 !LTU; 010/011 never taken.
//    LOAD: RDEN2=1, no PC_WRITE; next WB.
//    STORE: WE2=1 held in EXEC until MEM_RDY; PC_WRITE=1 only in the MEM_RDY cycle.
//    SYSTEM func3!=000: CSR_WE=1, RF_WE=1, PC_WRITE=1. func3==000: see CONFIGURATION.
//    Any other opcode: PC_WRITE=1 only (illegal executes as NOP).
//  - WB: RDEN2=1; hold until MEM_RDY; in that cycle RF_WE=1, PC_WRITE=1.
//  - Commit = cycle with PC_WRITE=1 in EXEC or WB; after commit next state FETCH
//    (or INTR, see CONFIGURATION). CU_INSTRET += 1 per commit, wraps 2^CNT_W-1 -> 0.
//  - ADD with zero-wait memory: 2 cycles/instr; load: 3 cycles minimum.
// CONFIGURATION
//  OTTER_INTR_EN defined:
//    - Commit cycle with CU_INTR & CU_MIE -> INTR instead of FETCH.
//    - INTR (1 cycle): PC_WRITE=1, PCSOURCE=4, INT_TAKEN=1, CSR_WE=0; then FETCH.
//    - SYSTEM func3==000 (mret): PC_WRITE=1, PCSOURCE=5, MRET_EXEC=1.
//    - INTR cycle is not a commit; CU_INSTRET unchanged.
//  OTTER_INTR_EN undefined:
//    - CU_INTR/CU_MIE ignored; INTR unreachable; INT_TAKEN, MRET_EXEC tied 0.
//    - SYSTEM func3==000 executes as NOP (PC_WRITE=1, PCSOURCE=0).
// TESTING
//  1. ADD 0110011, MEM_RDY=1 -> FETCH,EXEC repeat; EXEC RF_WE=1 PC_WRITE=1 PCSOURCE=0; INSTRET 0->1.
//  2. BRANCH func3=001: EQ=1 -> PCSOURCE=0; EQ=0 -> 2; func3=010 any flags -> 0; PC_WRITE=1 each.
//  3. LOAD, MEM_RDY low 3 WB cycles -> RDEN2 held, RF_WE/PC_WRITE only in RDY cycle, then FETCH.
//  4. STORE, RST asserted mid-EXEC with MEM_RDY=0 -> WE2=0 same cycle, STATE=0, INSTRET=0.
//  5. INTR_EN: CU_INTR=1 MIE=1 during ADD EXEC -> INTR next, PCSOURCE=4, INT_TAKEN 1 cycle;
//     MIE=0 -> FETCH; mret 1110011/000 -> PCSOURCE=5, MRET_EXEC=1.
//  6. CNT_W=4: 16 ADD commits -> CU_INSTRET wraps 15 -> 0.

Source files
------------

// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multi-cycle sequencing FSM of the OTTER RV32I control unit.
// Drives PC, register-file, memory and CSR strobes plus the PC source select.
// The decode half is a separate combinational block.
// Optional interrupt support (interrupt entry and mret) is enabled by defining OTTER_INTR_EN.
// Strobes are combinational from state and inputs.
// State and the retired-instruction counter are registered with an asynchronous reset.
module otter_cu_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       cu_opcode,
    input  logic [2:0]       cu_func3,
    input  logic             cu_br_eq,
    input  logic             cu_br_lt,
    input  logic             cu_br_ltu,
    input  logic             cu_mem_rdy,
    input  logic             cu_intr,
    input  logic             cu_mie,
    output logic             cu_pc_write,
    output logic [2:0]       cu_pcsource,
    output logic             cu_rf_we,
    output logic             cu_mem_rden1,
    output logic             cu_mem_rden2,
    output logic             cu_mem_we2,
    output logic             cu_csr_we,
    output logic             cu_int_taken,
    output logic             cu_mret_exec,
    output logic [1:0]       cu_state,
    output logic [CNT_W-1:0] cu_instret
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;
    localparam logic [1:0] ST_INTR  = 2'd3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] PCS_PLUS4  = 3'd0;
    localparam logic [2:0] PCS_JALR   = 3'd1;
    localparam logic [2:0] PCS_BRANCH = 3'd2;
    localparam logic [2:0] PCS_JAL    = 3'd3;
    localparam logic [2:0] PCS_MTVEC  = 3'd4;
    localparam logic [2:0] PCS_MEPC   = 3'd5;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] instret_reg;

    logic       pc_write, rf_we, rden1, rden2, we2, csr_we, int_taken, mret_exec;
    logic [2:0] pcsource;
    logic       br_taken;
    logic       commit;

`ifndef OTTER_INTR_EN
    // Interrupt inputs have no effect without interrupt support.
    logic unused_intr;
    assign unused_intr = cu_intr ^ cu_mie;
`endif

    // Branch condition from func3; 010/011 are not valid branches and never take.
    always_comb begin
        br_taken = 1'b0;
        case (cu_func3)
            3'b000:  br_taken = cu_br_eq;
            3'b001:  br_taken = ~cu_br_eq;
            3'b100:  br_taken = cu_br_lt;
            3'b101:  br_taken = ~cu_br_lt;
            3'b110:  br_taken = cu_br_ltu;
            3'b111:  br_taken = ~cu_br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // Strobe decode and next-state selection.
    always_comb begin
        state_next = state_reg;
        pc_write   = 1'b0;
        pcsource   = PCS_PLUS4;
        rf_we      = 1'b0;
        rden1      = 1'b0;
        rden2      = 1'b0;
        we2        = 1'b0;
        csr_we     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                rden1 = 1'b1;
                if (cu_mem_rdy) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (cu_opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                        rf_we    = 1'b1;
                        pc_write = 1'b1;
                    end
                    OPC_JAL: begin
                        rf_we    = 1'b1;
                        pc_write = 1'b1;
                        pcsource = PCS_JAL;
                    end
                    OPC_JALR: begin
                        rf_we    = 1'b1;
                        pc_write = 1'b1;
                        pcsource = PCS_JALR;
                    end
                    OPC_BRANCH: begin
                        pc_write = 1'b1;
                        pcsource = br_taken ? PCS_BRANCH : PCS_PLUS4;
                    end
                    OPC_LOAD: begin
                        rden2      = 1'b1;
                        state_next = ST_WB;
                    end
                    OPC_STORE: begin
                        // The write is held until memory accepts it; only then does the PC advance.
                        we2      = 1'b1;
                        pc_write = cu_mem_rdy;
                    end
                    OPC_SYSTEM: begin
                        if (cu_func3 != 3'b000) begin
                            csr_we   = 1'b1;
                            rf_we    = 1'b1;
                            pc_write = 1'b1;
                        end else begin
`ifdef OTTER_INTR_EN
                            pc_write  = 1'b1;
                            pcsource  = PCS_MEPC;
                            mret_exec = 1'b1;
`else
                            pc_write  = 1'b1;
`endif
                        end
                    end
                    default: begin
                        // An illegal opcode executes as a NOP so that the core keeps running.
                        pc_write = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                rden2 = 1'b1;
                if (cu_mem_rdy) begin
                    rf_we    = 1'b1;
                    pc_write = 1'b1;
                end
            end
            default: begin
`ifdef OTTER_INTR_EN
                pc_write  = 1'b1;
                pcsource  = PCS_MTVEC;
                int_taken = 1'b1;
`endif
                state_next = ST_FETCH;
            end
        endcase

        // A commit is the PC update that completes an instruction. Interrupt entry is not a commit.
        commit = pc_write && ((state_reg == ST_EXEC) || (state_reg == ST_WB));
        if (commit) begin
            state_next = ST_FETCH;
`ifdef OTTER_INTR_EN
            if (cu_intr && cu_mie) state_next = ST_INTR;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_FETCH;
        else     state_reg <= state_next;
    end

    // Retired-instruction counter; it wraps naturally at its full width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret_reg <= '0;
        else if (commit) instret_reg <= instret_reg + CNT_W'(1);
    end

    // Strobes are forced low while reset is held, so an aborted instruction leaves no write behind.
    assign cu_pc_write  = pc_write  & ~rst;
    assign cu_pcsource  = rst ? PCS_PLUS4 : pcsource;
    assign cu_rf_we     = rf_we     & ~rst;
    assign cu_mem_rden1 = rden1     & ~rst;
    assign cu_mem_rden2 = rden2     & ~rst;
    assign cu_mem_we2   = we2       & ~rst;
    assign cu_csr_we    = csr_we    & ~rst;
    assign cu_int_taken = int_taken & ~rst;
    assign cu_mret_exec = mret_exec & ~rst;
    assign cu_state     = state_reg;
    assign cu_instret   = instret_reg;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb_otter_cu_fsm: directed scoreboard bench for otter_cu_fsm.
// Two instances share every input: the default 32-bit counter and a 4-bit counter used to observe the wrap.
module tb_otter_cu_fsm;

    localparam logic [6:0] OP_ADD    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_ILL    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  cu_opcode;
    logic [2:0]  cu_func3;
    logic        cu_br_eq, cu_br_lt, cu_br_ltu, cu_mem_rdy, cu_intr, cu_mie;

    logic        pc_write_a, rf_we_a, rden1_a, rden2_a, we2_a, csr_we_a, int_taken_a, mret_a;
    logic [2:0]  pcsource_a;
    logic [1:0]  state_a;
    logic [31:0] instret_a;

    logic        pc_write_b, rf_we_b, rden1_b, rden2_b, we2_b, csr_we_b, int_taken_b, mret_b;
    logic [2:0]  pcsource_b;
    logic [1:0]  state_b;
    logic [3:0]  instret_b;

    int unsigned vec_cnt  = 0;
    int unsigned miss_cnt = 0;
    logic [31:0] exp_instret = 32'd0;

    typedef struct packed {
        logic [1:0]  state;
        logic [10:0] strb;
        logic [31:0] instret;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    otter_cu_fsm dut (
        .clk(clk), .rst(rst), .cu_opcode(cu_opcode), .cu_func3(cu_func3),
        .cu_br_eq(cu_br_eq), .cu_br_lt(cu_br_lt), .cu_br_ltu(cu_br_ltu),
        .cu_mem_rdy(cu_mem_rdy), .cu_intr(cu_intr), .cu_mie(cu_mie),
        .cu_pc_write(pc_write_a), .cu_pcsource(pcsource_a), .cu_rf_we(rf_we_a),
        .cu_mem_rden1(rden1_a), .cu_mem_rden2(rden2_a), .cu_mem_we2(we2_a),
        .cu_csr_we(csr_we_a), .cu_int_taken(int_taken_a), .cu_mret_exec(mret_a),
        .cu_state(state_a), .cu_instret(instret_a)
    );

    otter_cu_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cu_opcode(cu_opcode), .cu_func3(cu_func3),
        .cu_br_eq(cu_br_eq), .cu_br_lt(cu_br_lt), .cu_br_ltu(cu_br_ltu),
        .cu_mem_rdy(cu_mem_rdy), .cu_intr(cu_intr), .cu_mie(cu_mie),
        .cu_pc_write(pc_write_b), .cu_pcsource(pcsource_b), .cu_rf_we(rf_we_b),
        .cu_mem_rden1(rden1_b), .cu_mem_rden2(rden2_b), .cu_mem_we2(we2_b),
        .cu_csr_we(csr_we_b), .cu_int_taken(int_taken_b), .cu_mret_exec(mret_b),
        .cu_state(state_b), .cu_instret(instret_b)
    );

    // Expected strobe vector: {pc_write, pcsource, rf_we, rden1, rden2, we2, csr_we, int_taken, mret_exec}.
    function automatic logic [10:0] mk(logic pcw, logic [2:0] pcs, logic rfwe, logic rd1, logic rd2,
                                       logic we2, logic csr, logic it, logic mret);
        return {pcw, pcs, rfwe, rd1, rd2, we2, csr, it, mret};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expected result for the current inputs, then pop and compare it mid-cycle.
    // Before returning, advance past the next rising edge.
    task automatic step(string tag, logic [1:0] st, logic [10:0] strb);
        exp_t e;
        exp_t got;
        e.state   = st;
        e.strb    = strb;
        e.instret = exp_instret;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        chk({tag, ".state"}, {30'd0, state_a}, {30'd0, got.state});
        chk({tag, ".strb"},
            {21'd0, pc_write_a, pcsource_a, rf_we_a, rden1_a, rden2_a, we2_a, csr_we_a, int_taken_a, mret_a},
            {21'd0, got.strb});
        chk({tag, ".strb4"},
            {21'd0, pc_write_b, pcsource_b, rf_we_b, rden1_b, rden2_b, we2_b, csr_we_b, int_taken_b, mret_b},
            {21'd0, got.strb});
        chk({tag, ".instret"}, instret_a, got.instret);
        chk({tag, ".instret4"}, {28'd0, instret_b}, {28'd0, got.instret[3:0]});
        $display("step %-12s state=%0d strb=%03h instret=%0d instret4=%0d", tag, state_a,
                 {pc_write_a, pcsource_a, rf_we_a, rden1_a, rden2_a, we2_a, csr_we_a, int_taken_a, mret_a},
                 instret_a, instret_b);
        if (!rst && got.strb[10] && (got.state == 2'd1 || got.state == 2'd2))
            exp_instret = exp_instret + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic [6:0] op, logic [2:0] f3, logic eq, logic lt, logic ltu, logic rdy);
        cu_opcode  = op;
        cu_func3   = f3;
        cu_br_eq   = eq;
        cu_br_lt   = lt;
        cu_br_ltu  = ltu;
        cu_mem_rdy = rdy;
    endtask

    localparam logic [10:0] S_FETCH = 11'b0_000_0100000;
    localparam logic [10:0] S_ALU   = 11'b1_000_1000000;

    initial begin
        rst = 1'b1;
        cu_intr = 1'b0;
        cu_mie  = 1'b0;
        set_in(OP_ADD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("reset", 2'd0, 11'd0);
        rst = 1'b0;

        // Fetch waits on memory, then an ADD runs in two cycles.
        set_in(OP_ADD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fetch_wait", 2'd0, S_FETCH);
        cu_mem_rdy = 1'b1;
        step("fetch", 2'd0, S_FETCH);
        step("add_exec", 2'd1, S_ALU);
        step("fetch2", 2'd0, S_FETCH);
        step("add_exec2", 2'd1, S_ALU);

        // Branch outcomes.
        set_in(OP_BRANCH, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
        step("bne_f", 2'd0, S_FETCH);
        step("bne_nt", 2'd1, mk(1, 3'd0, 0, 0, 0, 0, 0, 0, 0));
        cu_br_eq = 1'b0;
        step("bne_f2", 2'd0, S_FETCH);
        step("bne_t", 2'd1, mk(1, 3'd2, 0, 0, 0, 0, 0, 0, 0));
        set_in(OP_BRANCH, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1);
        step("b010_f", 2'd0, S_FETCH);
        step("b010", 2'd1, mk(1, 3'd0, 0, 0, 0, 0, 0, 0, 0));
        set_in(OP_BRANCH, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
        step("bltu_f", 2'd0, S_FETCH);
        step("bltu_t", 2'd1, mk(1, 3'd2, 0, 0, 0, 0, 0, 0, 0));
        set_in(OP_BRANCH, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
        step("bge_f", 2'd0, S_FETCH);
        step("bge_nt", 2'd1, mk(1, 3'd0, 0, 0, 0, 0, 0, 0, 0));

        // Jumps.
        set_in(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("jal_f", 2'd0, S_FETCH);
        step("jal", 2'd1, mk(1, 3'd3, 1, 0, 0, 0, 0, 0, 0));
        set_in(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("jalr_f", 2'd0, S_FETCH);
        step("jalr", 2'd1, mk(1, 3'd1, 1, 0, 0, 0, 0, 0, 0));

        // Load with three wait cycles in write-back.
        set_in(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        step("ld_f", 2'd0, S_FETCH);
        cu_mem_rdy = 1'b0;
        step("ld_exec", 2'd1, mk(0, 3'd0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step("ld_wb_wait", 2'd2, mk(0, 3'd0, 0, 0, 1, 0, 0, 0, 0));
        cu_mem_rdy = 1'b1;
        step("ld_wb", 2'd2, mk(1, 3'd0, 1, 0, 1, 0, 0, 0, 0));
        step("ld_next", 2'd0, S_FETCH);

        // Store held until memory accepts it.
        set_in(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_exec_w", 2'd1, mk(0, 3'd0, 0, 0, 0, 1, 0, 0, 0));
        step("st_exec_w2", 2'd1, mk(0, 3'd0, 0, 0, 0, 1, 0, 0, 0));
        cu_mem_rdy = 1'b1;
        step("st_exec", 2'd1, mk(1, 3'd0, 0, 0, 0, 1, 0, 0, 0));

        // CSR access, mret/NOP, and an illegal opcode.
        set_in(OP_SYSTEM, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        step("csr_f", 2'd0, S_FETCH);
        step("csrrw", 2'd1, mk(1, 3'd0, 1, 0, 0, 0, 1, 0, 0));
        set_in(OP_SYSTEM, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("sys0_f", 2'd0, S_FETCH);
`ifdef OTTER_INTR_EN
        step("mret", 2'd1, mk(1, 3'd5, 0, 0, 0, 0, 0, 0, 1));
`else
        step("sys0_nop", 2'd1, mk(1, 3'd0, 0, 0, 0, 0, 0, 0, 0));
`endif
        set_in(OP_ILL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("ill_f", 2'd0, S_FETCH);
        step("ill_nop", 2'd1, mk(1, 3'd0, 0, 0, 0, 0, 0, 0, 0));

        // Interrupt entry at an ADD commit.
        set_in(OP_ADD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("irq_f", 2'd0, S_FETCH);
        cu_intr = 1'b1;
        cu_mie  = 1'b1;
        step("irq_exec", 2'd1, S_ALU);
`ifdef OTTER_INTR_EN
        step("irq_entry", 2'd3, mk(1, 3'd4, 0, 0, 0, 0, 0, 1, 0));
`endif
        step("irq_after", 2'd0, S_FETCH);
        cu_mie = 1'b0;
        step("mie0_exec", 2'd1, S_ALU);
        step("mie0_after", 2'd0, S_FETCH);
        cu_intr = 1'b0;
        step("mie0_exec2", 2'd1, S_ALU);

        // Commit a run of ADDs so the 4-bit counter wraps 15 -> 0 at least once.
        for (int i = 0; i < 18; i++) begin
            step("wrap_f", 2'd0, S_FETCH);
            step("wrap_exec", 2'd1, S_ALU);
        end

        // Reset in the middle of a stalled store aborts the write immediately.
        set_in(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rst_st_f", 2'd0, S_FETCH);
        cu_mem_rdy = 1'b0;
        step("rst_st_exec", 2'd1, mk(0, 3'd0, 0, 0, 0, 1, 0, 0, 0));
        rst = 1'b1;
        exp_instret = 32'd0;
        step("rst_mid_st", 2'd0, 11'd0);
        rst = 1'b0;
        set_in(OP_ADD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("post_rst_f", 2'd0, S_FETCH);
        step("post_rst_ex", 2'd1, S_ALU);
        step("post_rst_f2", 2'd0, S_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
